// File: rtl/axi_fourchan_sched_pkg.sv
// Shared types and defaults for the four-channel logic-link TX scheduler.
package axi_fourchan_sched_pkg;

    localparam int DEF_DATA_W = 74;
    localparam int DEF_NUM_CH = 4;

    typedef enum logic [1:0] {
        CH_AW = 2'd0,
        CH_W  = 2'd1,
        CH_AR = 2'd2,
        CH_RB = 2'd3
    } ch_id_e;

    function automatic int credit_w(input int max_credit);
        return $clog2(max_credit + 1);
    endfunction

endpackage

// File: rtl/ll_rr_arb4.sv
// Four-way round-robin arbiter: first requester at or after ptr wins.
module ll_rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_fourchan_tx_sched.sv
// Credit-aware round-robin scheduler merging four AXI channel streams
// onto one logic-link TX slot, tagging each word with its channel ID.
module axi_fourchan_tx_sched
    import axi_fourchan_sched_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int INIT_CREDIT = 8,
    parameter int MAX_CREDIT  = 15
) (
    input  logic                     clk_wr,
    input  logic                     rst_wr_n,
    input  logic                     sched_en,
    input  logic [NUM_CH-1:0]        ch_tx_valid,
    output logic [NUM_CH-1:0]        ch_tx_ready,
    input  logic [NUM_CH*DATA_W-1:0] ch_tx_data,
    input  logic [NUM_CH-1:0]        credit_return,
    output logic                     link_valid,
    input  logic                     link_ready,
    output logic [DATA_W-1:0]        link_data,
    output logic [1:0]               link_chid,
    output logic [NUM_CH-1:0]        credit_avail,
    output logic [NUM_CH-1:0]        credit_overflow
);

    localparam int CREDIT_W = credit_w(MAX_CREDIT);

    logic [CREDIT_W-1:0] cred_q [NUM_CH];
    logic [CREDIT_W-1:0] cred_d [NUM_CH];
    logic [NUM_CH-1:0]   ovf_q, ovf_d;

    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    ch_id_e              chid_q, chid_d;
    logic [1:0]          ptr_q, ptr_d;

    logic [NUM_CH-1:0]   eligible;
    logic [NUM_CH-1:0]   req;
    logic [3:0]          gnt;
    logic [1:0]          gnt_id;
    logic                free;
    logic                grant;
    logic [DATA_W-1:0]   sel_data;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            credit_avail[i] = (cred_q[i] != '0);
        end
    end

    assign eligible = ch_tx_valid & credit_avail;
    // Register is free when empty or draining this very cycle.
    assign free     = !valid_q || link_ready;
    assign req      = (sched_en && free && rst_wr_n) ? eligible : '0;
    assign grant    = |gnt;

    ll_rr_arb4 u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_data = ch_tx_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        chid_d  = chid_q;
        ptr_d   = ptr_q;
        if (grant) begin
            valid_d = 1'b1;
            data_d  = sel_data;
            chid_d  = ch_id_e'(gnt_id);
            ptr_d   = gnt_id + 2'd1;
        end else if (link_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cred_d[i] = cred_q[i];
            ovf_d[i]  = ovf_q[i];
            unique case ({gnt[i], credit_return[i]})
                2'b10: cred_d[i] = cred_q[i] - CREDIT_W'(1);
                2'b01: begin
                    if (cred_q[i] == CREDIT_W'(MAX_CREDIT)) begin
                        ovf_d[i] = 1'b1;
                    end else begin
                        cred_d[i] = cred_q[i] + CREDIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chid_q  <= CH_AW;
            ptr_q   <= '0;
            ovf_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cred_q[i] <= CREDIT_W'(INIT_CREDIT);
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            chid_q  <= chid_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cred_q[i] <= cred_d[i];
            end
        end
    end

    assign ch_tx_ready     = gnt[NUM_CH-1:0];
    assign link_valid      = valid_q;
    assign link_data       = data_q;
    assign link_chid       = chid_q;
    assign credit_overflow = ovf_q;

endmodule

// File: doc/axi_fourchan_tx_sched.md
Name: axi_fourchan_tx_sched

Overview:
- Credit-aware round-robin scheduler for four AXI logic-link transmit channels (AW, W, AR, B/R slot order ch0..ch3, 74-bit words each).
- Shares one 74-bit link slot between the four channels, one word per cycle, and tags each word with its channel ID.
- Sits between the per-channel AXI packers and the logic-link TX FIFO.
- Only sends a word when the far side has returned a credit for that channel.

Parameters:
- DATA_W, 74, width of one channel word.
- NUM_CH, 4, number of requesting channels (fixed at 4 in this release).
- INIT_CREDIT, 8, per-channel credit count loaded at reset.
- MAX_CREDIT, 15, credit saturation limit; CREDIT_W = $clog2(MAX_CREDIT+1).

Ports:
- clk_wr, input, 1, scheduler clock.
- rst_wr_n, input, 1, asynchronous active-low reset.
- sched_en, input, 1, allows new grants when high.
- ch_tx_valid, input, NUM_CH, per-channel word valid.
- ch_tx_ready, output, NUM_CH, per-channel accept (one-hot or zero).
- ch_tx_data, input, NUM_CH*DATA_W, channel i occupies [i*DATA_W +: DATA_W].
- credit_return, input, NUM_CH, one-cycle pulse per returned credit, per channel.
- link_valid, output, 1, output word valid.
- link_ready, input, 1, TX FIFO accepts the word.
- link_data, output, DATA_W, scheduled word.
- link_chid, output, 2, channel ID of link_data.
- credit_avail, output, NUM_CH, credit count of channel i > 0.
- credit_overflow, output, NUM_CH, sticky: a return arrived while the count was at MAX_CREDIT.

Behaviour:
- Reset (async, rst_wr_n low):
  - link_valid=0, link_data=0, link_chid=0, ch_tx_ready=0.
  - All credit counters = INIT_CREDIT; credit_avail all 1 if INIT_CREDIT>0.
  - credit_overflow=0, RR pointer=0.
- Eligibility: eligible[i] = ch_tx_valid[i] & (credit[i]!=0).
- Output stage is a single register. It is free when link_valid==0, or when link_valid & link_ready in the same cycle (pass-through drain).
- Grant: if sched_en & free & |eligible:
  - Select the first eligible channel starting at the RR pointer, wrapping 3->0.
  - ch_tx_ready[g]=1, combinational in that cycle; all other ready bits are 0.
  - Next edge: link_data<=ch_tx_data[g], link_chid<=g, link_valid<=1, pointer<=(g+1) mod 4.
- Transfer: a channel's word transfers when ch_tx_valid[i] & ch_tx_ready[i]. Latency is 1 cycle from accepted channel word to link_valid.
- link_valid holds and link_data/link_chid stay stable until link_ready. When a drain has no new grant, link_valid falls to 0.
- sched_en low: no grants, pointer frozen, an already-registered word still drains.
- No eligible channel: pointer unchanged.
- Credit counter per channel, clamped to [0, MAX_CREDIT]:
  - Grant alone: -1.
  - credit_return alone: +1.
  - Grant and return in the same cycle: unchanged.
  - Return with count at MAX_CREDIT and no same-cycle grant: count stays MAX_CREDIT, credit_overflow[i]<=1 (sticky until reset).
- Count 0 never grants, so there is no underflow. A return at count 0 makes the channel eligible on the next cycle, not the same cycle.
- Reset mid-operation: the pending output word is discarded, credits reload to INIT_CREDIT, and no partial word is emitted.

Decomposition:
- Package axi_fourchan_sched_pkg holds:
  - the channel-ID typedef (2-bit enum CH_AW=0, CH_W=1, CH_AR=2, CH_RB=3);
  - the DATA_W/NUM_CH defaults;
  - the credit counter width function.
- Sub-module ll_rr_arb4 holds the 4-way round-robin arbiter: req[3:0] and ptr[1:0] in, one-hot gnt[3:0] and gnt_id[1:0] out, purely combinational.
- The pointer register stays in the top level.

Test Plan:
1. After reset, all four channels hold valid constantly with data 0xA0..0xA3 and link_ready=1 -> link_chid sequence 0,1,2,3,0,... one word per cycle. Each channel stops after 8 grants (credit_avail drops to 0), and link_valid=0 afterwards.
2. Channel 2 alone valid with credits exhausted; pulse credit_return[2] once -> exactly one word with link_chid=2 one cycle after the following grant cycle, then credit_avail[2]=0 again.
3. link_ready held low for 5 cycles with link_valid=1 -> link_data/link_chid stable, ch_tx_ready all 0. When ready rises, the next word appears the following cycle with no bubble.
4. Channel 1 at 15 credits gets credit_return[1] -> count stays 15 and credit_overflow[1]=1, which persists through the next grants. A grant plus a return in the same cycle at count 5 -> count stays 5.
5. sched_en dropped while one word is registered -> that word drains, then no grants. Re-enable -> arbitration resumes from the frozen pointer.
6. Assert rst_wr_n low while link_valid=1 and credits are partly used -> link_valid falls immediately (async), credits read back as 8 after release, and no stale word is emitted.
